// File: rtl/screen_pkg.sv
// Shared definitions for the game-over / replay screen: sequencer states,
// loading-bar geometry and the RGB565 palette agreed with the pixel decoders.
package screen_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL    = 2'd1,
    PROMPT  = 2'd2,
    RESTART = 2'd3
  } state_e;

  localparam int NUM_SEGS  = 4;
  localparam int SEG_CNT_W = $clog2(NUM_SEGS + 1);
  localparam logic [SEG_CNT_W-1:0] LAST_SEG = SEG_CNT_W'(NUM_SEGS - 1);

  localparam logic [15:0] RGB_BLACK  = 16'h0000;
  localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
  localparam logic [15:0] RGB_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_GREY   = 16'h8410;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;

  // Thermometer code: n lit segments starting from the leftmost (bit 0).
  function automatic logic [NUM_SEGS-1:0] seg_mask_of(input logic [SEG_CNT_W-1:0] n);
    logic [NUM_SEGS:0] w_one;
    logic [NUM_SEGS:0] w_full;
    w_one  = {{NUM_SEGS{1'b0}}, 1'b1};
    w_full = (w_one << n) - w_one;
    return w_full[NUM_SEGS-1:0];
  endfunction

endpackage

// File: rtl/replay_screen_ctrl_frame_divider.sv
// Counts enabled frame ticks modulo PERIOD and flags the tick that wraps.
module frame_divider #(
  parameter int unsigned PERIOD = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_wrap
);

  localparam int unsigned CNT_W = $clog2(PERIOD + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_wrap = i_en && (r_cnt == LAST);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/replay_screen_ctrl.sv
// Game-over screen sequencer: paced loading-bar fill, blinking REPLAY prompt,
// then a one-cycle restart on a fresh button press or prompt timeout.
module replay_screen_ctrl
  import screen_pkg::*;
#(
  parameter int unsigned FILL_FRAMES    = 15,
  parameter int unsigned BLINK_FRAMES   = 30,
  parameter int unsigned TIMEOUT_FRAMES = 600
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                game_over,
  input  logic                btn_replay,
  output logic                screen_on,
  output logic [NUM_SEGS-1:0] seg_mask,
  output logic                replay_on,
  output logic                restart,
  output logic                busy
);

  localparam int unsigned TO_W = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_FRAMES > 0) ? TIMEOUT_FRAMES - 1 : 0);
  localparam logic [TO_W-1:0] TO_MAX  = '1;

  state_e                 r_state, w_state_nxt;
  logic                   r_btn_prev;
  logic [SEG_CNT_W-1:0]   r_seg_cnt, w_seg_cnt_nxt;
  logic [TO_W-1:0]        r_to_cnt, w_to_cnt_nxt;
  logic                   r_screen_on, r_replay_on, r_restart, r_busy;
  logic [NUM_SEGS-1:0]    r_seg_mask;
  logic                   w_replay_nxt;
  logic                   w_press;
  logic                   w_fill_en, w_fill_wrap;
  logic                   w_blink_en, w_blink_wrap;

  assign w_press    = btn_replay && !r_btn_prev;
  assign w_fill_en  = (r_state == FILL) && frame_tick;
  // A press wins over the blink update in the same cycle.
  assign w_blink_en = (r_state == PROMPT) && frame_tick && !w_press;

  frame_divider #(.PERIOD(FILL_FRAMES)) u_fill_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_fill_en),
    .i_clr  (r_state != FILL),
    .o_wrap (w_fill_wrap)
  );

  frame_divider #(.PERIOD(BLINK_FRAMES)) u_blink_div (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_blink_en),
    .i_clr  (r_state != PROMPT),
    .o_wrap (w_blink_wrap)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt   = r_state;
    w_seg_cnt_nxt = r_seg_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_replay_nxt  = r_replay_on;
    case (r_state)
      IDLE: begin
        w_seg_cnt_nxt = '0;
        w_to_cnt_nxt  = '0;
        w_replay_nxt  = 1'b0;
        if (game_over) w_state_nxt = FILL;
      end
      FILL: begin
        if (w_fill_wrap) begin
          w_seg_cnt_nxt = r_seg_cnt + SEG_CNT_W'(1);
          if (r_seg_cnt == LAST_SEG) begin
            w_state_nxt  = PROMPT;
            w_replay_nxt = 1'b1;
            w_to_cnt_nxt = '0;
          end
        end
      end
      PROMPT: begin
        if (w_press) begin
          w_state_nxt = RESTART;
        end else begin
          if (w_blink_wrap) w_replay_nxt = !r_replay_on;
          if (frame_tick) begin
            if (r_to_cnt != TO_MAX) w_to_cnt_nxt = r_to_cnt + TO_W'(1);
            if ((TIMEOUT_FRAMES != 0) && (r_to_cnt == TO_LAST)) w_state_nxt = RESTART;
          end
        end
      end
      RESTART: begin
        w_state_nxt   = IDLE;
        w_seg_cnt_nxt = '0;
        w_to_cnt_nxt  = '0;
        w_replay_nxt  = 1'b0;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_btn_prev  <= 1'b1;
      r_seg_cnt   <= '0;
      r_to_cnt    <= '0;
      r_screen_on <= 1'b0;
      r_seg_mask  <= '0;
      r_replay_on <= 1'b0;
      r_restart   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_btn_prev  <= btn_replay;
      r_seg_cnt   <= w_seg_cnt_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_screen_on <= (w_state_nxt != IDLE);
      r_seg_mask  <= seg_mask_of(w_seg_cnt_nxt);
      r_replay_on <= w_replay_nxt;
      r_restart   <= (w_state_nxt == RESTART);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign screen_on = r_screen_on;
  assign seg_mask  = r_seg_mask;
  assign replay_on = r_replay_on;
  assign restart   = r_restart;
  assign busy      = r_busy;

endmodule

// File: tb/tb_replay_screen_ctrl.sv
// Self-checking bench: two instances (timeout 5 and timeout disabled) share
// stimulus; directed scenarios plus a random run against a tick-count model.
module tb_replay_screen_ctrl;

  localparam int FILL_F  = 2;
  localparam int BLINK_F = 3;
  localparam int TO_A    = 5;

  localparam int M_IDLE    = 0;
  localparam int M_FILL    = 1;
  localparam int M_PROMPT  = 2;
  localparam int M_RESTART = 3;

  logic       clk, rst, frame_tick, game_over, btn_replay;
  logic       so_o   [2];
  logic [3:0] mask_o [2];
  logic       rep_o  [2];
  logic       rs_o   [2];
  logic       busy_o [2];

  int checks = 0;
  int errors = 0;

  // Model: per instance, the mode plus ticks seen in FILL and in PROMPT.
  int   m_mode   [2];
  int   m_fill   [2];
  int   m_prompt [2];
  logic m_prev;

  replay_screen_ctrl #(.FILL_FRAMES(FILL_F), .BLINK_FRAMES(BLINK_F), .TIMEOUT_FRAMES(TO_A)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_over(game_over), .btn_replay(btn_replay),
    .screen_on(so_o[0]), .seg_mask(mask_o[0]), .replay_on(rep_o[0]), .restart(rs_o[0]), .busy(busy_o[0])
  );

  replay_screen_ctrl #(.FILL_FRAMES(FILL_F), .BLINK_FRAMES(BLINK_F), .TIMEOUT_FRAMES(0)) dut_nt (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_over(game_over), .btn_replay(btn_replay),
    .screen_on(so_o[1]), .seg_mask(mask_o[1]), .replay_on(rep_o[1]), .restart(rs_o[1]), .busy(busy_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int timeout_of(input int k);
    return (k == 0) ? TO_A : 0;
  endfunction

  task automatic model_update(input logic t, input logic g, input logic b, input logic r);
    logic press;
    if (r) begin
      for (int k = 0; k < 2; k++) begin
        m_mode[k] = M_IDLE; m_fill[k] = 0; m_prompt[k] = 0;
      end
      m_prev = 1'b1;
      return;
    end
    press  = b && !m_prev;
    m_prev = b;
    for (int k = 0; k < 2; k++) begin
      case (m_mode[k])
        M_IDLE: if (g) begin m_mode[k] = M_FILL; m_fill[k] = 0; end
        M_FILL: if (t) begin
          m_fill[k]++;
          if (m_fill[k] == 4 * FILL_F) begin m_mode[k] = M_PROMPT; m_prompt[k] = 0; end
        end
        M_PROMPT: begin
          if (press) m_mode[k] = M_RESTART;
          else if (t) begin
            m_prompt[k]++;
            if (timeout_of(k) != 0 && m_prompt[k] == timeout_of(k)) m_mode[k] = M_RESTART;
          end
        end
        default: m_mode[k] = M_IDLE;
      endcase
    end
  endtask

  function automatic logic [3:0] exp_mask(input int k);
    logic [4:0] one;
    one = 5'd1;
    case (m_mode[k])
      M_IDLE: return 4'h0;
      M_FILL: return 4'((one << (m_fill[k] / FILL_F)) - one);
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic exp_replay(input int k);
    if (m_mode[k] == M_PROMPT) return ((m_prompt[k] / BLINK_F) % 2) == 0;
    return 1'b0;
  endfunction

  task automatic step(input logic t, input logic g, input logic b, input logic r);
    @(negedge clk);
    frame_tick = t; game_over = g; btn_replay = b; rst = r;
    @(posedge clk);
    model_update(t, g, b, r);
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({so_o[k], mask_o[k], rep_o[k], rs_o[k], busy_o[k]} !== 8'h00) begin
        errors++;
        $display("FAIL reset_outputs[%0d] got %b exp 00000000", k,
                 {so_o[k], mask_o[k], rep_o[k], rs_o[k], busy_o[k]});
      end
    end
    step(0, 0, 1, 0);
    checks++;
    if (rs_o[0] !== 1'b0 || busy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_held_btn got restart=%b busy=%b exp 0 0", rs_o[0], busy_o[0]);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_fill_timing();
    logic [4:0] one;
    logic [3:0] exp;
    one = 5'd1;
    step(0, 1, 0, 0);
    checks++;
    if (so_o[0] !== 1'b1 || mask_o[0] !== 4'h0) begin
      errors++;
      $display("FAIL fill_entry got screen_on=%b mask=%b exp 1 0000", so_o[0], mask_o[0]);
    end
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, 0);
      exp = 4'((one << (i / 2)) - one);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (mask_o[k] !== exp || rep_o[k] !== (i == 8)) begin
          errors++;
          $display("FAIL fill_tick%0d[%0d] got mask=%b replay=%b exp %b %b",
                   i, k, mask_o[k], rep_o[k], exp, (i == 8));
        end
      end
    end
  endtask

  task automatic test_blink_press();
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (rep_o[1] !== (((i / 3) % 2) == 0) || rs_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL blink_tick%0d got replay=%b restart_a=%b exp %b 0",
                 i, rep_o[1], rs_o[0], (((i / 3) % 2) == 0));
      end
    end
    step(0, 0, 1, 0);
    checks++;
    if (rs_o[0] !== 1'b1 || rs_o[1] !== 1'b1 || so_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL press_restart got restart=%b%b screen_on=%b exp 11 1", rs_o[0], rs_o[1], so_o[0]);
    end
    step(0, 0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rs_o[k] !== 1'b0 || so_o[k] !== 1'b0 || mask_o[k] !== 4'h0 || busy_o[k] !== 1'b0) begin
        errors++;
        $display("FAIL press_after[%0d] got restart=%b screen_on=%b mask=%b busy=%b exp 0 0 0000 0",
                 k, rs_o[k], so_o[k], mask_o[k], busy_o[k]);
      end
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_held_button();
    step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    for (int i = 0; i < 11; i++) begin
      step(i < 8, 0, 1, 0);
      checks++;
      if (rs_o[0] !== 1'b0 || rs_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL held_no_restart cycle%0d got restart=%b%b exp 00", i, rs_o[0], rs_o[1]);
      end
    end
    checks++;
    if (mask_o[0] !== 4'hF) begin
      errors++;
      $display("FAIL held_in_prompt got mask=%b exp 1111", mask_o[0]);
    end
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    checks++;
    if (rs_o[0] !== 1'b1 || rs_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL held_repress got restart=%b%b exp 11", rs_o[0], rs_o[1]);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_timeout();
    logic seen_b;
    step(0, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 0, 0);
      checks++;
      if (rs_o[0] !== (i == 5) || rs_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL timeout_tick%0d got restart=%b%b exp %b0", i, rs_o[0], rs_o[1], (i == 5));
      end
    end
    seen_b = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step(1, 0, 0, 0);
      if (i == 0) begin
        checks++;
        if (rs_o[0] !== 1'b0 || so_o[0] !== 1'b0) begin
          errors++;
          $display("FAIL timeout_after got restart=%b screen_on=%b exp 0 0", rs_o[0], so_o[0]);
        end
      end
      seen_b |= (rs_o[1] !== 1'b0);
    end
    checks++;
    if (seen_b !== 1'b0 || so_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_disabled got restart_seen=%b screen_on=%b exp 0 1", seen_b, so_o[1]);
    end
    step(0, 0, 1, 0);
    checks++;
    if (rs_o[1] !== 1'b1) begin
      errors++;
      $display("FAIL timeout_disabled_press got restart=%b exp 1", rs_o[1]);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_ignored_events();
    logic [3:0] exp_tab [9];
    exp_tab = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h3, 4'h7, 4'h7, 4'hF};
    step(1, 1, 0, 0);
    checks++;
    if (so_o[0] !== 1'b1 || mask_o[0] !== 4'h0) begin
      errors++;
      $display("FAIL go_with_tick got screen_on=%b mask=%b exp 1 0000", so_o[0], mask_o[0]);
    end
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) begin
        step(0, 1, 0, 0);
        checks++;
        if (mask_o[0] !== 4'h3 || busy_o[0] !== 1'b1) begin
          errors++;
          $display("FAIL ignored_go got mask=%b busy=%b exp 0011 1", mask_o[0], busy_o[0]);
        end
      end
      step(1, 0, 0, 0);
      checks++;
      if (mask_o[0] !== exp_tab[i]) begin
        errors++;
        $display("FAIL ignored_tick%0d got mask=%b exp %b", i, mask_o[0], exp_tab[i]);
      end
    end
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    checks++;
    if (rs_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL press_and_timeout got restart=%b exp 1", rs_o[0]);
    end
    step(0, 0, 1, 0);
    checks++;
    if (rs_o[0] !== 1'b0 || so_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL press_and_timeout_single got restart=%b screen_on=%b exp 0 0", rs_o[0], so_o[0]);
    end
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset_mid_fill();
    step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    checks++;
    if (mask_o[0] !== 4'h7) begin
      errors++;
      $display("FAIL midfill_pre got mask=%b exp 0111", mask_o[0]);
    end
    step(0, 0, 0, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({so_o[k], mask_o[k], rep_o[k], rs_o[k], busy_o[k]} !== 8'h00) begin
        errors++;
        $display("FAIL midfill_reset[%0d] got %b exp 00000000", k,
                 {so_o[k], mask_o[k], rep_o[k], rs_o[k], busy_o[k]});
      end
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    checks++;
    if (mask_o[0] !== 4'h0 || so_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL midfill_rego got mask=%b screen_on=%b exp 0000 1", mask_o[0], so_o[0]);
    end
    step(1, 0, 0, 0);
    checks++;
    if (mask_o[0] !== 4'h1) begin
      errors++;
      $display("FAIL midfill_rego_seg got mask=%b exp 0001", mask_o[0]);
    end
  endtask

  task automatic test_random();
    logic t, g, b, r;
    b = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      t = ($urandom_range(0, 1) == 1);
      g = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) b = !b;
      r = ($urandom_range(0, 499) == 0);
      step(t, g, b, r);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (so_o[k] !== (m_mode[k] != M_IDLE) || busy_o[k] !== (m_mode[k] != M_IDLE)) begin
          errors++;
          $display("FAIL rand_screen[%0d] cyc%0d got screen_on=%b busy=%b exp %b",
                   k, n, so_o[k], busy_o[k], (m_mode[k] != M_IDLE));
        end
        checks++;
        if (mask_o[k] !== exp_mask(k)) begin
          errors++;
          $display("FAIL rand_mask[%0d] cyc%0d got %b exp %b", k, n, mask_o[k], exp_mask(k));
        end
        checks++;
        if (rs_o[k] !== (m_mode[k] == M_RESTART)) begin
          errors++;
          $display("FAIL rand_restart[%0d] cyc%0d got %b exp %b", k, n, rs_o[k], (m_mode[k] == M_RESTART));
        end
        if (m_mode[k] != M_RESTART) begin
          checks++;
          if (rep_o[k] !== exp_replay(k)) begin
            errors++;
            $display("FAIL rand_replay[%0d] cyc%0d got %b exp %b", k, n, rep_o[k], exp_replay(k));
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; game_over = 1'b0; btn_replay = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_fill[k] = 0; m_prompt[k] = 0;
    end
    m_prev = 1'b1;
    test_reset();
    test_fill_timing();
    test_blink_press();
    test_held_button();
    test_timeout();
    test_ignored_events();
    test_reset_mid_fill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
